// File: rtl/pipe_pkg.sv
// Shared widths and control types for the inter-stage pipeline registers.
// Stage registers enable their optional skid slot with PIPE_STAGE_SKID_EN.
package pipe_pkg;

  localparam int unsigned PIPE_MEMWB_W = 110;
  localparam int unsigned PIPE_EXMEM_W = 107;
  localparam int unsigned PIPE_IDEX_W  = 150;
  localparam int unsigned PIPE_IFID_W  = 64;

  // Per-stage control produced by the hazard unit.
  typedef struct packed {
    logic flush;
    logic stall;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between adjacent pipeline stages.
// The master drives Valid/Data; the slave drives Ready.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 110
) ();

  logic             Valid;
  logic             Ready;
  logic [WIDTH-1:0] Data;

  modport master (
    output Valid,
    output Data,
    input  Ready
  );

  modport slave (
    input  Valid,
    input  Data,
    output Ready
  );

endinterface

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a valid bit plus payload register.
// Reset and flush both empty the slot and load FLUSH_VALUE.
module pipe_slot #(
  parameter int unsigned      WIDTH       = 110,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             Load,
  input  logic             Clear,
  input  logic [WIDTH-1:0] LoadData,
  output logic             Valid,
  output logic [WIDTH-1:0] Data
);

  logic             validQ;
  logic [WIDTH-1:0] dataQ;

  // Clearing leaves dataQ untouched so the last payload stays visible.
  always_ff @(posedge Clk) begin
    if (!Rst || Flush) begin
      validQ <= 1'b0;
      dataQ  <= FLUSH_VALUE;
    end else if (Load) begin
      validQ <= 1'b1;
      dataQ  <= LoadData;
    end else if (Clear) begin
      validQ <= 1'b0;
    end
  end

  assign Valid = validQ;
  assign Data  = dataQ;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN to add a skid slot and register InReady.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = PIPE_MEMWB_W,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn
);

  logic             inReady;
  logic             accept;
  logic             consume;
  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic             mainLoad;
  logic             mainClear;
  logic [WIDTH-1:0] mainLoadData;

  assign accept    = up.Valid && inReady;
  assign consume   = mainValid && dn.Ready;
  assign mainClear = consume;
  assign up.Ready  = inReady;
  assign dn.Valid  = mainValid;
  assign dn.Data   = mainData;

`ifdef PIPE_STAGE_SKID_EN
  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic             skidLoad;
  logic             skidClear;
  logic             skidValidD;
  logic             readyQ;

  always_comb begin
    mainLoad     = (accept && (!mainValid || (consume && !skidValid))) ||
                   (consume && skidValid);
    mainLoadData = (consume && skidValid) ? skidData : up.Data;
    // A beat parks in skid when main is held, or refills skid while it drains.
    skidLoad     = accept && mainValid && (skidValid ? consume : !consume);
    skidClear    = consume && skidValid;
  end

  always_comb begin
    skidValidD = skidValid;
    if (Flush) begin
      skidValidD = 1'b0;
    end else if (skidLoad) begin
      skidValidD = 1'b1;
    end else if (skidClear) begin
      skidValidD = 1'b0;
    end
  end

  // Ready follows next-cycle skid occupancy so a full skid blocks upstream at once.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      readyQ <= 1'b1;
    end else begin
      readyQ <= !skidValidD;
    end
  end

  assign inReady = Rst && readyQ;

  pipe_slot #(
    .WIDTH       (WIDTH),
    .FLUSH_VALUE (FLUSH_VALUE)
  ) u_skid_slot (
    .Clk      (Clk),
    .Rst      (Rst),
    .Flush    (Flush),
    .Load     (skidLoad),
    .Clear    (skidClear),
    .LoadData (up.Data),
    .Valid    (skidValid),
    .Data     (skidData)
  );
`else
  always_comb begin
    mainLoad     = accept;
    mainLoadData = up.Data;
  end

  assign inReady = Rst && (!mainValid || dn.Ready);
`endif

  pipe_slot #(
    .WIDTH       (WIDTH),
    .FLUSH_VALUE (FLUSH_VALUE)
  ) u_main_slot (
    .Clk      (Clk),
    .Rst      (Rst),
    .Flush    (Flush),
    .Load     (mainLoad),
    .Clear    (mainClear),
    .LoadData (mainLoadData),
    .Valid    (mainValid),
    .Data     (mainData)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks for pipe_stage_reg in either skid setting.
// Expectations follow PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage_reg;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] FV = 8'hC3;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic         Clk;
  logic         Rst;
  logic         Flush;
  logic         inV;
  logic         outR;
  logic [W-1:0] inD;

  int vectors;
  int miscompares;

  pipe_stage_reg_if #(.WIDTH(W)) upIf ();
  pipe_stage_reg_if #(.WIDTH(W)) dnIf ();

  assign upIf.Valid = inV;
  assign upIf.Data  = inD;
  assign dnIf.Ready = outR;

  pipe_stage_reg #(
    .WIDTH       (W),
    .FLUSH_VALUE (FV)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Flush (Flush),
    .up    (upIf),
    .dn    (dnIf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [W-1:0] q[$];
  logic         acc;
  logic         cons;
  logic         expRdy;

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst   = 1'b0;
    Flush = 1'b0;
    inV   = 1'b1;
    inD   = 8'h5A;
    outR  = 1'b1;

    // Reset
    repeat (3) tick();
    check("reset_ov", dnIf.Valid, 0);
    check("reset_od", dnIf.Data, FV);
    check("reset_rdy", upIf.Ready, 0);
    Rst = 1'b1;
    inV = 1'b0;
    tick();
    check("rel_rdy", upIf.Ready, 1);
    check("rel_ov", dnIf.Valid, 0);

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      inV = 1'b1;
      inD = W'(i);
      #1;
      check("stream_rdy", upIf.Ready, 1);
      tick();
      check("stream_ov", dnIf.Valid, 1);
      check("stream_od", dnIf.Data, i);
    end
    inV = 1'b0;
    tick();
    check("stream_end_ov", dnIf.Valid, 0);

    // Back-pressure
    outR = 1'b0;
    inV  = 1'b1;
    inD  = 8'h0A;
    #1;
    check("bp_rdy_a", upIf.Ready, 1);
    tick();
    check("bp_hold_a", dnIf.Data, 8'h0A);
    inD = 8'h0B;
`ifdef PIPE_STAGE_SKID_EN
    #1;
    check("bp_rdy_b", upIf.Ready, 1);
    tick();
    check("bp_hold_a2", dnIf.Data, 8'h0A);
    check("bp_full_rdy", upIf.Ready, 0);
    inD = 8'h0C;
    tick();
    check("bp_hold_a3", dnIf.Data, 8'h0A);
    check("bp_hold_ov", dnIf.Valid, 1);
    check("bp_c_blocked", upIf.Ready, 0);
    outR = 1'b1;
    tick();
    check("bp_out_b", dnIf.Data, 8'h0B);
    check("bp_rdy_back", upIf.Ready, 1);
    tick();
    check("bp_out_c", dnIf.Data, 8'h0C);
    check("bp_out_c_ov", dnIf.Valid, 1);
`else
    #1;
    check("bp_rdy_b", upIf.Ready, 0);
    tick();
    check("bp_hold_a2", dnIf.Data, 8'h0A);
    check("bp_hold_ov", dnIf.Valid, 1);
    outR = 1'b1;
    #1;
    check("bp_rdy_back", upIf.Ready, 1);
    tick();
    check("bp_out_b", dnIf.Data, 8'h0B);
    inD = 8'h0C;
    tick();
    check("bp_out_c", dnIf.Data, 8'h0C);
    check("bp_out_c_ov", dnIf.Valid, 1);
`endif
    inV = 1'b0;
    tick();
    check("bp_end_ov", dnIf.Valid, 0);

    // Flush while full
    outR = 1'b0;
    inV  = 1'b1;
    inD  = 8'h11;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    inD = 8'h22;
    tick();
    check("ff_full_rdy", upIf.Ready, 0);
`endif
    Flush = 1'b1;
    inD   = 8'h33;
    tick();
    Flush = 1'b0;
    inV   = 1'b0;
    check("ff_ov", dnIf.Valid, 0);
    check("ff_od", dnIf.Data, FV);
    check("ff_rdy", upIf.Ready, 1);
    outR = 1'b1;
    tick();
    check("ff_gone_ov", dnIf.Valid, 0);

    // Flush discards a beat handshaked in the same cycle
    inV   = 1'b1;
    inD   = 8'h33;
    Flush = 1'b1;
    #1;
    check("fa_rdy", upIf.Ready, 1);
    tick();
    Flush = 1'b0;
    inV   = 1'b0;
    check("fa_ov", dnIf.Valid, 0);
    check("fa_od", dnIf.Data, FV);
    tick();
    check("fa_gone_ov", dnIf.Valid, 0);

    // Consume and accept in the same cycle
    outR = 1'b0;
    inV  = 1'b1;
    inD  = 8'h44;
    tick();
    check("ca_od_44", dnIf.Data, 8'h44);
    outR = 1'b1;
    inD  = 8'h55;
    #1;
    check("ca_rdy", upIf.Ready, 1);
    tick();
    check("ca_od_55", dnIf.Data, 8'h55);
    check("ca_ov", dnIf.Valid, 1);
    inV = 1'b0;
    #1;
    check("ca_skid_empty", upIf.Ready, 1);
    tick();
    check("ca_end_ov", dnIf.Valid, 0);

    // Random valid/ready/flush against an in-order scoreboard
    for (int n = 0; n < 10000; n++) begin
      inV   = 1'($urandom_range(0, 1));
      inD   = W'($urandom_range(0, 255));
      outR  = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 49) == 0);
      #1;
      expRdy = Skid ? (q.size() < 2) : (q.size() == 0 || outR);
      check("rnd_rdy", upIf.Ready, expRdy);
      check("rnd_ov", dnIf.Valid, q.size() > 0);
      if (q.size() > 0) begin
        check("rnd_od", dnIf.Data, q[0]);
      end
      acc  = inV && upIf.Ready;
      cons = (q.size() > 0) && outR;
      tick();
      if (Flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(inD);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
